// File: rtl/keypad_defs.sv
// rtl/keypad_defs.sv - shared FSM/frame-result encodings and the 4x4 hex key map
package keypad_defs;

  typedef enum logic [1:0] {
    IDLE,
    DEB_PRESS,
    PRESSED,
    DEB_RELEASE
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    KEY,
    MULTI
  } frame_res_t;

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'h0;
      4'hD: code = 4'hF;
      4'hE: code = 4'hE;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_col_scan.sv
// rtl/keypad_col_scan.sv - column drive sequencer and 4x4 frame capture
module keypad_col_scan
  import keypad_defs::*;
#(
  parameter int SCAN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        e,
  input  logic [3:0]  row_sync,
  output logic [3:0]  col,
  output logic [15:0] frame,
  output logic        frame_done
);

  localparam int CW = (SCAN > 1) ? $clog2(SCAN) : 1;

  logic          running_q, running_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    col_q, col_d;
  logic [11:0]   cap_q, cap_d;
  logic          sample;

  // The first enabled edge only starts driving col0; counting begins from there.
  always_comb begin
    sample    = running_q && e && (cnt_q == CW'(SCAN - 1));
    running_d = running_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    col_d     = col_q;
    cap_d     = cap_q;
    if (!e) begin
      running_d = 1'b0;
      cnt_d     = '0;
      idx_d     = 2'd0;
      col_d     = 4'hF;
    end else if (!running_q) begin
      running_d = 1'b1;
      cnt_d     = '0;
      idx_d     = 2'd0;
      col_d     = 4'b1110;
    end else if (sample) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
      col_d = ~(4'b0001 << idx_d);
      case (idx_q)
        2'd0:    cap_d[3:0]  = row_sync;
        2'd1:    cap_d[7:4]  = row_sync;
        2'd2:    cap_d[11:8] = row_sync;
        default: cap_d       = cap_q;
      endcase
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      running_q <= 1'b0;
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      col_q     <= 4'hF;
      cap_q     <= 12'hFFF;
    end else begin
      running_q <= running_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      col_q     <= col_d;
      cap_q     <= cap_d;
    end
  end

  // The col3 sample bypasses the capture register so the frame is judged on its own sample cycle.
  assign frame      = {row_sync, cap_q};
  assign frame_done = sample && (idx_q == 2'd3);
  assign col        = col_q;

endmodule

// File: rtl/keypad_scan_32b.sv
// rtl/keypad_scan_32b.sv - 4x4 hex keypad scanner with frame debounce and 32-bit digit entry
module keypad_scan_32b
  import keypad_defs::*;
#(
  parameter int SCAN     = 10**5/2,
  parameter int DEBOUNCE = 20
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        e,
  input  logic        clr,
  input  logic [3:0]  ROW,
  output logic [3:0]  COL,
  output logic [31:0] x,
  output logic [3:0]  key_code,
  output logic        key_valid
);

  localparam int DW = $clog2(DEBOUNCE + 1);

  logic [3:0]  row_s1_q, row_s2_q;
  logic [15:0] frame;
  logic        frame_done;

  keypad_col_scan #(.SCAN(SCAN)) u_col_scan (
    .clk        (CLK),
    .rst        (RST),
    .e          (e),
    .row_sync   (row_s2_q),
    .col        (COL),
    .frame      (frame),
    .frame_done (frame_done)
  );

  frame_res_t res;
  logic [4:0] n_hits;
  logic [3:0] frame_code;

  always_comb begin
    n_hits     = 5'd0;
    frame_code = 4'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!frame[c*4 + r]) begin
          n_hits     = n_hits + 5'd1;
          frame_code = key_map(2'(r), 2'(c));
        end
      end
    end
    if (n_hits == 5'd0)      res = NONE;
    else if (n_hits == 5'd1) res = KEY;
    else                     res = MULTI;
  end

  state_t        state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [3:0]    cand_q, cand_d;
  logic [31:0]   x_q, x_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          accept;
  logic [3:0]    acc_code;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    accept   = 1'b0;
    acc_code = cand_q;
    if (!e) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (frame_done) begin
      case (state_q)
        IDLE: begin
          if (res == KEY) begin
            cand_d = frame_code;
            cnt_d  = DW'(1);
            if (DEBOUNCE <= 1) begin
              accept   = 1'b1;
              acc_code = frame_code;
              state_d  = PRESSED;
            end else begin
              state_d = DEB_PRESS;
            end
          end
        end
        DEB_PRESS: begin
          if (res != KEY) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (frame_code != cand_q) begin
            cand_d = frame_code;
            cnt_d  = DW'(1);
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == DW'(DEBOUNCE)) begin
              accept  = 1'b1;
              state_d = PRESSED;
            end
          end
        end
        PRESSED: begin
          if (res == NONE) begin
            cnt_d = DW'(1);
            if (DEBOUNCE <= 1) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              state_d = DEB_RELEASE;
            end
          end
        end
        default: begin
          if (res == NONE) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == DW'(DEBOUNCE)) begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end else begin
            state_d = PRESSED;
            cnt_d   = '0;
          end
        end
      endcase
    end

    key_valid_d = accept;
    key_code_d  = accept ? acc_code : key_code_q;
    // clr outranks a coincident accept; the accepted code still reports.
    if (clr)         x_d = 32'h0;
    else if (accept) x_d = {x_q[27:0], acc_code};
    else             x_d = x_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      row_s1_q    <= 4'hF;
      row_s2_q    <= 4'hF;
      state_q     <= IDLE;
      cnt_q       <= '0;
      cand_q      <= 4'h0;
      x_q         <= 32'h0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
    end else begin
      row_s1_q    <= ROW;
      row_s2_q    <= row_s1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      x_q         <= x_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign x         = x_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_scan_32b.sv
// tb/tb_keypad_scan_32b.sv - scoreboard bench for keypad_scan_32b with a modelled 4x4 keypad
module tb_keypad_scan_32b;

  logic        CLK = 1'b0;
  logic        RST, e, clr;
  logic [3:0]  ROW, COL;
  logic [31:0] x;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [15:0] keys;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [3:0]  code;
    logic [31:0] xv;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] x_m;
  logic        kv_prev = 1'b0;
  int          pos_tab[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};

  keypad_scan_32b #(.SCAN(4), .DEBOUNCE(2)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .e         (e),
    .clr       (clr),
    .ROW       (ROW),
    .COL       (COL),
    .x         (x),
    .key_code  (key_code),
    .key_valid (key_valid)
  );

  always #5 CLK = ~CLK;

  // Key index is row*4+col; a held key pulls its row low only while its column is driven.
  always_comb begin
    ROW = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4 + c] && !COL[c]) ROW[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge CLK) begin
    if (!RST && key_valid) begin
      check("no_back_to_back", {31'b0, kv_prev}, 32'h0);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pulse: key_code %h x %h with no press expected", key_code, x);
      end else begin
        exp_t ex;
        ex = exp_q.pop_front();
        check("key_code", {28'b0, key_code}, {28'b0, ex.code});
        check("x_on_pulse", x, ex.xv);
      end
    end
    kv_prev = key_valid;
  end

  task automatic expect_key(input logic [3:0] code);
    x_m = {x_m[27:0], code};
    exp_q.push_back({code, x_m});
  endtask

  task automatic align();
    logic [3:0] prev;
    prev = COL;
    for (int n = 0; n < 64; n++) begin
      @(posedge CLK);
      #1;
      if (COL == 4'b1110 && prev != 4'b1110) return;
      prev = COL;
    end
    vectors++;
    miscompares++;
    $display("FAIL align: COL %h never restarted at col0", COL);
  endtask

  task automatic hold(input int pos, input int on_frames, input int off_frames);
    align();
    keys = 16'b1 << pos;
    repeat (on_frames * 16) @(posedge CLK);
    #1 keys = 16'h0;
    repeat (off_frames * 16) @(posedge CLK);
    #1;
  endtask

  initial begin
    int n;
    RST  = 1'b1;
    e    = 1'b1;
    clr  = 1'b0;
    keys = 16'h0;
    x_m  = 32'h0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_col", {28'b0, COL}, 32'hF);
    check("reset_x", x, 32'h0);
    check("reset_key_valid", {31'b0, key_valid}, 32'h0);
    check("reset_key_code", {28'b0, key_code}, 32'h0);
    RST = 1'b0;

    expect_key(4'h5);
    hold(5, 4, 4);
    check("x_after_5", x, 32'h5);

    hold(3, 1, 3);
    check("x_after_bounce", x, 32'h5);
    expect_key(4'hA);
    hold(3, 2, 3);

    align();
    keys = 16'h8001;
    repeat (4 * 16) @(posedge CLK);
    #1 keys = 16'h0;
    repeat (3 * 16) @(posedge CLK);
    #1;
    check("x_after_multi", x, 32'h5A);

    for (int i = 0; i < 9; i++) begin
      expect_key(4'(i + 1));
      hold(pos_tab[i], 3, 3);
    end
    check("x_after_sequence", x, 32'h23456789);

    align();
    x_m = 32'h0;
    exp_q.push_back({4'h7, 32'h0});
    keys = 16'b1 << 8;
    repeat (31) @(posedge CLK);
    #1 clr = 1'b1;
    @(posedge CLK);
    #1 clr = 1'b0;
    check("clr_accept_valid", {31'b0, key_valid}, 32'h1);
    check("clr_accept_x", x, 32'h0);
    keys = 16'h0;
    repeat (3 * 16) @(posedge CLK);
    #1;

    align();
    keys = 16'b1 << 7;
    repeat (20) @(posedge CLK);
    #1 e = 1'b0;
    @(posedge CLK);
    #1;
    check("col_off", {28'b0, COL}, 32'hF);
    repeat (10) @(posedge CLK);
    #1 e = 1'b1;
    expect_key(4'hB);
    @(posedge CLK);
    #1;
    check("col_restart", {28'b0, COL}, 32'hE);
    n = 0;
    while (!key_valid && n < 40) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check("enable_latency", n, 32);
    keys = 16'h0;
    repeat (3 * 16) @(posedge CLK);
    #1;

    align();
    keys = 16'b1 << 11;
    repeat (20) @(posedge CLK);
    #1 RST = 1'b1;
    keys = 16'h0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    x_m = 32'h0;
    check("x_after_rst", x, 32'h0);
    repeat (3 * 16) @(posedge CLK);
    #1;

    repeat (20) @(posedge CLK);
    #1;
    check("pending_expect", exp_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
